// File: rtl/mn_hostif_pkg.sv
// Shared register map, bit positions and sizing helpers for the HPS mailbox slave.
package mn_hostif_pkg;

  localparam logic [31:0] DEFAULT_ID = 32'h4D42_0001;

  localparam int REG_ID      = 0;
  localparam int REG_CTRL    = 1;
  localparam int REG_STATUS  = 2;
  localparam int REG_THRESH  = 3;
  localparam int REG_TX_DATA = 4;
  localparam int REG_RX_DATA = 5;
  localparam int REG_SCRATCH = 6;
  localparam int REG_RX_TS   = 7;

  localparam int CTRL_IRQ_EN = 0;
  localparam int CTRL_FLUSH  = 1;

  localparam int ST_RX_COUNT_LSB = 0;
  localparam int ST_TX_COUNT_LSB = 8;
  localparam int ST_RX_EMPTY     = 16;
  localparam int ST_TX_FULL      = 17;
  localparam int ST_TX_OVERFLOW  = 24;
  localparam int ST_RX_UNDERFLOW = 25;
  localparam int ST_PARTIAL_ERR  = 26;

  // Count must hold 0..depth inclusive, hence one bit more than the pointer.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // A 256-deep FIFO can report 256, which does not fit the 8-bit STATUS field.
  function automatic logic [7:0] sat8(input logic [15:0] c);
    return (c > 16'd255) ? 8'hFF : c[7:0];
  endfunction

endpackage

// File: rtl/mn_hostif_sync_fifo.sv
// Show-ahead synchronous FIFO with flush; push while full succeeds only with a same-cycle pop.
module mn_hostif_sync_fifo
  import mn_hostif_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = count_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr_reg];
  assign count   = count_reg;

  always_ff @(posedge clk) begin
    if (do_push && !flush && !srst) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // Flush has priority over any same-cycle push or pop.
  always_ff @(posedge clk) begin
    if (srst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/mn_hostif_mbox_slave.sv
// Avalon-MM register file with TX/RX word mailboxes and a level IRQ for the HPS lightweight bridge.
// Optional MBOX_RX_TIMESTAMP_EN adds a cycle counter and per-word RX timestamps readable at register 7.
module mn_hostif_mbox_slave
  import mn_hostif_pkg::*;
#(
  parameter int          ADDR_WIDTH = 4,
  parameter int          DATA_WIDTH = 32,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [31:0] ID_VALUE   = DEFAULT_ID
) (
  input  logic                  clk100_clk,
  input  logic                  reset_clk100_reset,
  input  logic [ADDR_WIDTH-1:0] avs_address,
  input  logic                  avs_read,
  input  logic                  avs_write,
  input  logic [3:0]            avs_byteenable,
  input  logic [DATA_WIDTH-1:0] avs_writedata,
  output logic [DATA_WIDTH-1:0] avs_readdata,
  output logic                  avs_readdatavalid,
  output logic                  avs_waitrequest,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  irq
);

  localparam int CW = count_width(FIFO_DEPTH);

  logic                  srst;
  logic                  wait_reg;
  logic                  live;
  logic                  rd_acc;
  logic                  wr_acc;
  logic                  full_be;
  logic [DATA_WIDTH-1:0] be_mask;

  logic                  irq_en_reg;
  logic [7:0]            thresh_reg;
  logic [DATA_WIDTH-1:0] scratch_reg;
  logic [DATA_WIDTH-1:0] scratch_next;
  logic                  tx_ovf_reg;
  logic                  rx_unf_reg;
  logic                  partial_reg;
  logic                  irq_reg;
  logic [DATA_WIDTH-1:0] rdata_reg;
  logic                  rdv_reg;
  logic [DATA_WIDTH-1:0] rd_mux;
  logic [DATA_WIDTH-1:0] rx_ts;

  logic wr_ctrl, wr_status, wr_thresh, wr_tx, wr_scratch, rd_rx;
  logic flush;

  logic                  tx_push_req, tx_pop, tx_full, tx_empty;
  logic [CW-1:0]         tx_count;
  logic [DATA_WIDTH-1:0] tx_dout;
  logic                  rx_push, rx_pop, rx_full, rx_empty;
  logic [CW-1:0]         rx_count;
  logic [DATA_WIDTH-1:0] rx_dout;

  assign srst = reset_clk100_reset;
  // live is low during reset and for one cycle after it, gating bus and stream traffic.
  assign live    = ~wait_reg & ~srst;
  assign rd_acc  = avs_read & live;
  assign wr_acc  = avs_write & live;
  assign full_be = (avs_byteenable == 4'hF);

  genvar gi;
  generate
    for (gi = 0; gi < DATA_WIDTH / 8; gi++) begin : g_lane
      assign be_mask[gi*8 +: 8] = {8{avs_byteenable[gi]}};
    end
  endgenerate

  assign wr_ctrl    = wr_acc & (avs_address == ADDR_WIDTH'(REG_CTRL));
  assign wr_status  = wr_acc & (avs_address == ADDR_WIDTH'(REG_STATUS));
  assign wr_thresh  = wr_acc & (avs_address == ADDR_WIDTH'(REG_THRESH));
  assign wr_tx      = wr_acc & (avs_address == ADDR_WIDTH'(REG_TX_DATA));
  assign wr_scratch = wr_acc & (avs_address == ADDR_WIDTH'(REG_SCRATCH));
  assign rd_rx      = rd_acc & (avs_address == ADDR_WIDTH'(REG_RX_DATA));

  assign flush = wr_ctrl & avs_byteenable[0] & avs_writedata[CTRL_FLUSH];

  assign tx_push_req = wr_tx & full_be;
  assign tx_valid    = ~tx_empty & ~srst;
  assign tx_data     = tx_dout;
  assign tx_pop      = tx_valid & tx_ready;

  assign rx_ready = ~rx_full & live;
  assign rx_push  = rx_valid & rx_ready;
  assign rx_pop   = rd_rx & ~rx_empty;

  mn_hostif_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk100_clk),
    .srst  (srst),
    .flush (flush),
    .push  (tx_push_req),
    .din   (avs_writedata),
    .pop   (tx_pop),
    .dout  (tx_dout),
    .count (tx_count),
    .full  (tx_full),
    .empty (tx_empty)
  );

  mn_hostif_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk100_clk),
    .srst  (srst),
    .flush (flush),
    .push  (rx_push),
    .din   (rx_data),
    .pop   (rx_pop),
    .dout  (rx_dout),
    .count (rx_count),
    .full  (rx_full),
    .empty (rx_empty)
  );

`ifdef MBOX_RX_TIMESTAMP_EN
  logic [31:0]   cycle_cnt_reg;
  logic [31:0]   last_ts_reg;
  logic [31:0]   ts_dout;
  logic          ts_full;
  logic          ts_empty;
  logic [CW-1:0] ts_count;

  always_ff @(posedge clk100_clk) begin
    if (srst) cycle_cnt_reg <= '0;
    else      cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
  end

  // Runs in lockstep with the RX FIFO, so its gating terms never actually block.
  mn_hostif_sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_ts_fifo (
    .clk   (clk100_clk),
    .srst  (srst),
    .flush (flush),
    .push  (rx_push & ~ts_full),
    .din   (cycle_cnt_reg),
    .pop   (rx_pop & (ts_count != '0)),
    .dout  (ts_dout),
    .count (ts_count),
    .full  (ts_full),
    .empty (ts_empty)
  );

  always_ff @(posedge clk100_clk) begin
    if (srst || flush)  last_ts_reg <= '0;
    else if (rx_pop)    last_ts_reg <= ts_empty ? 32'd0 : ts_dout;
  end

  assign rx_ts = DATA_WIDTH'(last_ts_reg);
`else
  assign rx_ts = '0;
`endif

  assign scratch_next = (scratch_reg & ~be_mask) | (avs_writedata & be_mask);

  always_comb begin
    rd_mux = '0;
    case (avs_address)
      ADDR_WIDTH'(REG_ID):      rd_mux = DATA_WIDTH'(ID_VALUE);
      ADDR_WIDTH'(REG_CTRL):    rd_mux[CTRL_IRQ_EN] = irq_en_reg;
      ADDR_WIDTH'(REG_STATUS): begin
        rd_mux[ST_RX_COUNT_LSB +: 8] = sat8(16'(rx_count));
        rd_mux[ST_TX_COUNT_LSB +: 8] = sat8(16'(tx_count));
        rd_mux[ST_RX_EMPTY]          = rx_empty;
        rd_mux[ST_TX_FULL]           = tx_full;
        rd_mux[ST_TX_OVERFLOW]       = tx_ovf_reg;
        rd_mux[ST_RX_UNDERFLOW]      = rx_unf_reg;
        rd_mux[ST_PARTIAL_ERR]       = partial_reg;
      end
      ADDR_WIDTH'(REG_THRESH):  rd_mux[7:0] = thresh_reg;
      ADDR_WIDTH'(REG_RX_DATA): rd_mux = rx_empty ? '0 : rx_dout;
      ADDR_WIDTH'(REG_SCRATCH): rd_mux = scratch_reg;
      ADDR_WIDTH'(REG_RX_TS):   rd_mux = rx_ts;
      default:                  rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk100_clk) begin
    if (srst) begin
      wait_reg    <= 1'b1;
      irq_en_reg  <= 1'b0;
      thresh_reg  <= '0;
      scratch_reg <= '0;
      tx_ovf_reg  <= 1'b0;
      rx_unf_reg  <= 1'b0;
      partial_reg <= 1'b0;
      irq_reg     <= 1'b0;
      rdata_reg   <= '0;
      rdv_reg     <= 1'b0;
    end else begin
      wait_reg <= 1'b0;
      if (wr_ctrl && avs_byteenable[0])   irq_en_reg  <= avs_writedata[CTRL_IRQ_EN];
      if (wr_thresh && avs_byteenable[0]) thresh_reg  <= avs_writedata[7:0];
      if (wr_scratch)                     scratch_reg <= scratch_next;
      // A new event in the same cycle as its W1C keeps the bit set.
      tx_ovf_reg  <= (tx_push_req & tx_full & ~tx_pop) |
                     (tx_ovf_reg & ~(wr_status & avs_writedata[ST_TX_OVERFLOW]));
      rx_unf_reg  <= (rd_rx & rx_empty) |
                     (rx_unf_reg & ~(wr_status & avs_writedata[ST_RX_UNDERFLOW]));
      partial_reg <= (wr_tx & ~full_be) |
                     (partial_reg & ~(wr_status & avs_writedata[ST_PARTIAL_ERR]));
      irq_reg <= irq_en_reg & (((thresh_reg != 8'd0) && (16'(rx_count) >= 16'(thresh_reg))) |
                               tx_ovf_reg | rx_unf_reg | partial_reg);
      rdv_reg <= rd_acc;
      if (rd_acc) rdata_reg <= rd_mux;
    end
  end

  assign avs_waitrequest   = wait_reg | srst;
  assign avs_readdata      = rdata_reg;
  assign avs_readdatavalid = rdv_reg & ~srst;
  assign irq               = irq_reg;

endmodule

// File: tb/tb_mn_hostif_mbox_slave.sv
// Scoreboard bench for mn_hostif_mbox_slave: stimulus queues expected read/TX words, a negedge monitor compares.
module tb_mn_hostif_mbox_slave;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [3:0]  avs_byteenable;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;
  logic        avs_waitrequest;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        irq;

  always #5 clk = ~clk;

  mn_hostif_mbox_slave dut (
    .clk100_clk         (clk),
    .reset_clk100_reset (reset),
    .avs_address        (avs_address),
    .avs_read           (avs_read),
    .avs_write          (avs_write),
    .avs_byteenable     (avs_byteenable),
    .avs_writedata      (avs_writedata),
    .avs_readdata       (avs_readdata),
    .avs_readdatavalid  (avs_readdatavalid),
    .avs_waitrequest    (avs_waitrequest),
    .tx_data            (tx_data),
    .tx_valid           (tx_valid),
    .tx_ready           (tx_ready),
    .rx_data            (rx_data),
    .rx_valid           (rx_valid),
    .rx_ready           (rx_ready),
    .irq                (irq)
  );

  typedef struct {
    string       name;
    logic [31:0] data;
  } exp_t;

  exp_t        rd_q[$];
  logic [31:0] tx_q[$];
  int          checks   = 0;
  int          failures = 0;

`ifdef MBOX_RX_TIMESTAMP_EN
  int unsigned cyc;
  int unsigned ts_exp;
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%08h required=%08h", name, act, exp);
    end
  endtask

  // Monitor: compares every read response and every TX handshake against the queues.
  always @(negedge clk) begin : monitor
    exp_t        e;
    logic [31:0] w;
    if (avs_readdatavalid === 1'b1) begin
      if (rd_q.size() == 0) begin
        check("rdv_unexpected", 32'd1, 32'd0);
      end else begin
        e = rd_q.pop_front();
        check(e.name, avs_readdata, e.data);
        $display("rd  %-14s data=%08h", e.name, avs_readdata);
      end
    end
    if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
      if (tx_q.size() == 0) begin
        check("tx_unexpected", 32'd1, 32'd0);
      end else begin
        w = tx_q.pop_front();
        check("tx_word", tx_data, w);
        $display("tx  data=%08h", tx_data);
      end
    end
  end

  task automatic bus_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] be);
    avs_write      = 1'b1;
    avs_address    = addr;
    avs_writedata  = data;
    avs_byteenable = be;
    @(posedge clk);
    #1;
    avs_write      = 1'b0;
    avs_byteenable = 4'h0;
    $display("wr  addr=%0d data=%08h be=%h", addr, data, be);
  endtask

  task automatic bus_read(input string name, input logic [3:0] addr, input logic [31:0] exp);
    avs_read    = 1'b1;
    avs_address = addr;
    rd_q.push_back('{name: name, data: exp});
    @(posedge clk);
    #1;
    avs_read = 1'b0;
    @(negedge clk);
    check({name, "_lat"}, {31'd0, avs_readdatavalid}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic rx_push(input logic [31:0] d);
    rx_valid = 1'b1;
    rx_data  = d;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    $display("rx  data=%08h", d);
  endtask

  task automatic check_irq_next_neg(input string name, input logic exp);
    @(negedge clk);
    check(name, {31'd0, irq}, {31'd0, exp});
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    reset = 1'b1;
    avs_address = '0; avs_read = 1'b0; avs_write = 1'b0;
    avs_byteenable = '0; avs_writedata = '0;
    tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;

    // 1: reset behaviour and basic reads
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_wait",     {31'd0, avs_waitrequest},   32'd1);
    check("rst_rdv",      {31'd0, avs_readdatavalid}, 32'd0);
    check("rst_tx_valid", {31'd0, tx_valid},          32'd0);
    check("rst_rx_ready", {31'd0, rx_ready},          32'd0);
    check("rst_irq",      {31'd0, irq},               32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rel_wait",     {31'd0, avs_waitrequest}, 32'd1);
    check("rel_rx_ready", {31'd0, rx_ready},        32'd0);
    @(negedge clk);
    check("run_wait",     {31'd0, avs_waitrequest}, 32'd0);
    check("run_rx_ready", {31'd0, rx_ready},        32'd1);
    @(posedge clk);
    #1;
    bus_read("id",      4'd0, 32'h4D42_0001);
    bus_read("ctrl0",   4'd1, 32'h0000_0000);
    bus_read("status0", 4'd2, 32'h0001_0000);

    // 2: fill TX, overflow, drain in order
    for (int i = 1; i <= 16; i++) bus_write(4'd4, 32'hA5A5_0000 + 32'(i), 4'hF);
    bus_read("status_full", 4'd2, 32'h0003_1000);
    bus_write(4'd4, 32'hA5A5_0011, 4'hF);
    bus_read("status_ovf", 4'd2, 32'h0103_1000);
    for (int i = 1; i <= 16; i++) tx_q.push_back(32'hA5A5_0000 + 32'(i));
    tx_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tx_valid !== 1'b1) break;
    end
    tx_ready = 1'b0;
    check("tx_drain_left", 32'(tx_q.size()), 32'd0);
    check("tx_valid_done", {31'd0, tx_valid}, 32'd0);
    @(posedge clk);
    #1;
    bus_write(4'd2, 32'h0100_0000, 4'hF);
    bus_read("status_ovf_clr", 4'd2, 32'h0001_0000);

    // 3: threshold interrupt
    bus_write(4'd3, 32'h0000_0003, 4'hF);
    bus_write(4'd1, 32'h0000_0001, 4'hF);
    rx_push(32'h1111_0001);
    rx_push(32'h1111_0002);
    rx_push(32'h1111_0003);
    @(negedge clk);
    check("irq_pre", {31'd0, irq}, 32'd0);
    check_irq_next_neg("irq_thresh", 1'b1);
    bus_read("rx_pop1", 4'd5, 32'h1111_0001);
    check_irq_next_neg("irq_after_pop", 1'b0);
    bus_read("rx_pop2", 4'd5, 32'h1111_0002);
    bus_read("rx_pop3", 4'd5, 32'h1111_0003);

    // 4: underflow and W1C
    bus_read("rx_empty_rd", 4'd5, 32'h0000_0000);
    @(negedge clk);
    check("irq_underflow", {31'd0, irq}, 32'd1);
    @(posedge clk);
    #1;
    bus_read("status_unf", 4'd2, 32'h0201_0000);
    bus_write(4'd2, 32'h0200_0000, 4'hF);
    @(posedge clk);
    @(negedge clk);
    check("irq_unf_clr", {31'd0, irq}, 32'd0);
    @(posedge clk);
    #1;
    bus_read("status_unf_clr", 4'd2, 32'h0001_0000);

    // 5: partial TX write and byte lanes
    bus_write(4'd4, 32'hDEAD_BEEF, 4'h3);
    bus_read("status_partial", 4'd2, 32'h0401_0000);
    check_irq_next_neg("irq_partial", 1'b1);
    bus_write(4'd2, 32'h0400_0000, 4'hF);
    bus_write(4'd6, 32'hFFFF_FFFF, 4'h5);
    bus_read("scratch_be5", 4'd6, 32'h00FF_00FF);
    bus_write(4'd6, 32'h1234_5678, 4'hA);
    bus_read("scratch_beA", 4'd6, 32'h12FF_56FF);
    bus_read("thresh", 4'd3, 32'h0000_0003);
    bus_read("unmapped9", 4'd9, 32'h0000_0000);

    // 6: flush beats same-cycle push and pop, sticky bits preserved
    bus_write(4'd4, 32'hC0DE_0001, 4'hF);
    bus_write(4'd4, 32'hC0DE_0002, 4'hF);
    rx_push(32'h2222_0001);
    bus_write(4'd4, 32'h0000_0000, 4'h1);
    rx_valid = 1'b1;
    rx_data  = 32'h2222_0002;
    tx_ready = 1'b1;
    tx_q.push_back(32'hC0DE_0001);
    bus_write(4'd1, 32'h0000_0003, 4'hF);
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    @(negedge clk);
    check("flush_tx_valid", {31'd0, tx_valid}, 32'd0);
    @(posedge clk);
    #1;
    bus_read("status_flush", 4'd2, 32'h0401_0000);
    bus_read("ctrl_flush", 4'd1, 32'h0000_0001);
`ifdef MBOX_RX_TIMESTAMP_EN
    bus_read("ts_after_flush", 4'd7, 32'h0000_0000);
    rx_valid = 1'b1;
    rx_data  = 32'h3333_0001;
    @(negedge clk);
    ts_exp = cyc;
    @(posedge clk);
    #1 rx_valid = 1'b0;
    bus_read("rx_post_flush", 4'd5, 32'h3333_0001);
    bus_read("ts_value", 4'd7, ts_exp);
`else
    rx_push(32'h3333_0001);
    bus_read("rx_post_flush", 4'd5, 32'h3333_0001);
    bus_read("reg7_zero", 4'd7, 32'h0000_0000);
`endif

    repeat (3) @(posedge clk);
    #1;
    check("rd_q_left", 32'(rd_q.size()), 32'd0);
    check("tx_q_left", 32'(tx_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mn_hostif_mbox_slave.md
Name: mn_hostif_mbox_slave

Overview:
Avalon-MM slave responder at the far end of the HPS lightweight bridge master (lw_bridge_m0: 32-bit data, burstcount 1, waitrequest/readdatavalid). It gives the HPS host a small register file and two word mailboxes. TX goes host->fabric as a valid/ready stream. RX goes fabric->host as a valid/ready stream, popped by register read. Its level interrupt drives the host IRQ input (hostif_irq_i_irq).

Parameters:
ADDR_WIDTH, 4, slave word-address width (register index)
DATA_WIDTH, 32, bus and mailbox word width
FIFO_DEPTH, 16, entries per mailbox FIFO; power of two, 2..256
ID_VALUE, 32'h4D42_0001, constant returned by the ID register

Ports:
clk100_clk  in  1  single clock for bus, FIFOs and streams
reset_clk100_reset  in  1  reset; one clock; reset is synchronous and active-high
avs_address  in  ADDR_WIDTH  word address
avs_read  in  1  read strobe
avs_write  in  1  write strobe
avs_byteenable  in  4  byte lanes for writes
avs_writedata  in  DATA_WIDTH  write data
avs_readdata  out  DATA_WIDTH  read data, valid with readdatavalid
avs_readdatavalid  out  1  read response strobe
avs_waitrequest  out  1  transfer stall
tx_data  out  DATA_WIDTH  host->fabric stream data
tx_valid  out  1  TX FIFO non-empty
tx_ready  in  1  fabric accepts tx_data
rx_data  in  DATA_WIDTH  fabric->host stream data
rx_valid  in  1  fabric offers rx_data
rx_ready  out  1  RX FIFO not full
irq  out  1  level interrupt to host

Behaviour:
- Register map (word index):
  - 0 ID, RO.
  - 1 CTRL, RW: bit0 irq_en; bit1 flush, write-1 self-clears.
  - 2 STATUS: [7:0] rx_count RO; [15:8] tx_count RO; bit16 rx_empty; bit17 tx_full; bit24 tx_overflow W1C; bit25 rx_underflow W1C; bit26 partial_err W1C.
  - 3 THRESH, RW [7:0].
  - 4 TX_DATA, WO push.
  - 5 RX_DATA, RO pop.
  - 6 SCRATCH, RW.
  - 7..max: read 0, writes ignored.
- Byteenable is honoured per lane on CTRL, THRESH and SCRATCH. TX_DATA push requires byteenable==4'hF; otherwise there is no push and partial_err is set.
- waitrequest: 1 while reset is asserted and on the first cycle after release; 0 otherwise. The slave never stalls a transfer.
- Read latency: fixed 1 cycle. readdata/readdatavalid are registered from the accepted read. readdatavalid is 0 in all other cycles. At most one read is outstanding.
- An RX_DATA read pops the RX head in the accept cycle; the popped word is returned next cycle.
  - RX empty: return 0, set rx_underflow, pointers unchanged.
- A TX_DATA write to a full TX FIFO drops the word and sets tx_overflow.
- FIFOs: count width clog2(FIFO_DEPTH)+1; pointers wrap modulo depth.
  - Same-cycle push and pop on one FIFO leaves the count unchanged.
  - Full FIFO with pop plus push: both succeed.
- Stream side:
  - tx_valid = TX non-empty; a pop occurs on tx_valid&tx_ready.
  - rx_ready = RX not full; a push occurs on rx_valid&rx_ready.
- Flush clears both FIFOs next cycle. Flush beats a same-cycle push or pop (data discarded). Sticky bits are unaffected.
- W1C of a sticky bit in the same cycle as a new set event: set wins.
- irq (registered, 1-cycle lag) = irq_en & ((THRESH!=0 & rx_count>=THRESH) | tx_overflow | rx_underflow | partial_err).
- Reset values:
  - Outputs: readdata 0, readdatavalid 0, waitrequest 1, tx_valid 0, rx_ready 0 (first cycle after reset, then 1), irq 0.
  - CTRL, THRESH, SCRATCH and sticky bits are 0; FIFOs are empty.
- Reset mid-operation: a pending readdatavalid is cancelled, FIFO contents are discarded, and the stream handshakes drop the same cycle.

Optional Feature:
MBOX_RX_TIMESTAMP_EN:
- Defined:
  - A free-running 32-bit cycle counter (wraps at 2^32, reset 0) runs continuously.
  - Every RX push captures the counter into a parallel timestamp FIFO of the same depth.
  - Register 7 (RO) returns the timestamp of the word most recently popped via RX_DATA; 0 after reset or flush.
- Undefined: no counter or timestamp storage; register 7 reads 0.

Decomposition:
- Package mn_hostif_pkg:
  - Register index localparams.
  - STATUS/CTRL bit positions.
  - Default ID value.
  - A function computing count width from depth.
- One sub-module, mn_hostif_sync_fifo (parameterised width/depth, push/pop/flush, count/full/empty), instantiated for TX, RX and, when the feature is defined, the timestamp FIFO.

Test Plan:
1. Reset then read ID -> waitrequest 1 during reset; readdatavalid exactly 1 cycle after the read with 32'h4D42_0001; CTRL/STATUS read 0 except rx_empty=1.
2. Write TX_DATA 0xA5A5_0001..0xA5A5_0010 (16) with tx_ready=0 -> tx_full=1, tx_count=16. A 17th write sets tx_overflow. tx_ready=1 then drains the 16 words in order.
3. Fabric pushes 3 words with THRESH=3 and irq_en=1 -> irq rises 1 cycle after the 3rd push. Three RX_DATA reads return the words in order; irq falls after the 1st pop.
4. Read RX_DATA while empty -> readdata 0, rx_underflow=1, irq=1 if enabled. Write 1 to STATUS bit25 -> bit clears and irq drops.
5. Write TX_DATA with byteenable 4'h3 -> no push, partial_err=1. Write SCRATCH 0xFFFF_FFFF with byteenable 4'h5 -> reads 0x00FF_00FF.
6. Flush asserted in the same cycle as an RX push and a tx_ready pop -> both counts 0 next cycle and sticky bits unchanged. With MBOX_RX_TIMESTAMP_EN, a subsequent push/pop gives a register 7 value equal to the counter at the push.
